chirp_spi_serializer: RTL

CHIRP_SPI_SERIALIZER -- requirements
Module: chirp_spi_serializer

---
 rtl/chirp_spi_pkg.sv | 30 +++
 rtl/chirp_spi_clkgen.sv | 42 ++++
 rtl/chirp_spi_serializer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/chirp_spi_pkg.sv
// chirp_spi_pkg
//   Shared definitions for the chirp SPI serializer: state encoding, the
//   default shift register width, device select constants and the chip
//   enable decode helper.
package chirp_spi_pkg;

  localparam int MAX_BITS_DEF = 32;

  localparam logic DEV_DAC = 1'b0;
  localparam logic DEV_VCO = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    TRAIL    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Active-low enable pattern for the selected device; the other bit stays high.
  function automatic logic [1:0] sen_sel(input logic dev);
    logic [1:0] pattern;
    pattern = 2'b11;
    if (dev == DEV_DAC) pattern = 2'b10;
    if (dev == DEV_VCO) pattern = 2'b01;
    return pattern;
  endfunction

endpackage

// File: rtl/chirp_spi_clkgen.sv
// chirp_spi_clkgen
//   Half-period tick generator for the serial clock. A DIV_W-bit down-counter
//   is loaded with half-1 when a transfer starts and reloads to half-1 on every
//   tick, so each sclk phase lasts exactly `half` system clocks.
//
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   hold   in   forces the counter to 0 and suppresses tick (controller idle)
//   load   in   loads half-1 (takes priority over hold)
//   half   in   half-period length in clocks, already forced to >= 1
//   tick   out  one-clock pulse on the last clock of each phase
module chirp_spi_clkgen #(
  parameter int DIV_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             load,
  input  logic [DIV_W-1:0] half,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !hold && !load && (cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half - DIV_W'(1);
    end else if (hold) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= half - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/chirp_spi_serializer.sv
// chirp_spi_serializer
//   SPI write serializer for the chirp DAC and VCO/PLL. A start in IDLE
//   latches the target, bit count, half period and data word, then shifts the
//   word out MSB-first on mosi with sclk idling low. Each phase (lead, sclk
//   high, sclk low, trail) lasts H system clocks, so the selected enable is
//   low for (2N+2)*H clocks. ready pulses for one clock when a transfer ends.
//
// Optional build macro
//   CHIRP_SPI_MISO_CAPTURE_EN  adds miso/readback: miso is shifted in at each
//                              sclk rise and copied to readback in DONE.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   device        in   0 = DAC (sen[0]), 1 = VCO/PLL (sen[1])
//   start_tr      in   transfer request, sampled only in IDLE
//   num_bits      in   bits to send (clamped to MAX_BITS, 0 = no transfer)
//   sclk_divider  in   sclk half period in clocks (0 treated as 1)
//   set_data      in   word to send, MSB-first, left-justified
//   miso          in   serial read data (macro builds only)
//   readback      out  captured read word (macro builds only)
//   ready         out  one-clock pulse at transfer completion
//   sen           out  active-low chip enables
//   sclk          out  serial clock
//   mosi          out  serial data
//
// State table
//   IDLE     | waiting for start_tr; enables high, sclk low
//   LEAD     | enable asserted, first bit on mosi, sclk low for H clocks
//   SHIFT_HI | sclk high for H clocks (slave samples on the rise)
//   SHIFT_LO | sclk low for H clocks, next bit presented on the fall
//   TRAIL    | all bits sent, enable still low, sclk low for H clocks
//   DONE     | enables released, ready pulse, back to IDLE
module chirp_spi_serializer
  import chirp_spi_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int DIV_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                device,
  input  logic                start_tr,
  input  logic [5:0]          num_bits,
  input  logic [DIV_W-1:0]    sclk_divider,
  input  logic [MAX_BITS-1:0] set_data,
`ifdef CHIRP_SPI_MISO_CAPTURE_EN
  input  logic                miso,
  output logic [MAX_BITS-1:0] readback,
`endif
  output logic                ready,
  output logic [1:0]          sen,
  output logic                sclk,
  output logic                mosi
);

  localparam int              IW      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [IW-1:0]   TOP_IDX = IW'(MAX_BITS - 1);
  localparam logic [6:0]      MAX_N   = 7'(MAX_BITS);

  state_t              state;
  state_t              state_nx;
  logic                dev_lat;
  logic [MAX_BITS-1:0] data_lat;
  logic [DIV_W-1:0]    h_lat;
  logic [6:0]          bits_left;
  logic [IW-1:0]       bit_idx;

  logic [DIV_W-1:0]    h_in;
  logic [DIV_W-1:0]    h_sel;
  logic [6:0]          n_in;
  logic                tick;
  logic                cg_load;
  logic                cg_hold;

  // Sanitised request values; the clock generator sees the live divider only
  // in the IDLE cycle that loads it, and the latched copy afterwards.
  always_comb begin
    h_in  = (sclk_divider == '0) ? DIV_W'(1) : sclk_divider;
    n_in  = (int'(num_bits) > MAX_BITS) ? MAX_N : {1'b0, num_bits};
    h_sel = (state == IDLE) ? h_in : h_lat;
  end

  assign cg_hold = (state == IDLE) || (state == DONE);

  chirp_spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clock (clock),
    .reset (reset),
    .hold  (cg_hold),
    .load  (cg_load),
    .half  (h_sel),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cg_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start_tr) begin
          if (n_in == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = LEAD;
            cg_load  = 1'b1;
          end
        end
      end
      LEAD:     if (tick) state_nx = SHIFT_HI;
      SHIFT_HI: if (tick) state_nx = SHIFT_LO;
      // bits_left reaches 0 at the fall of the last bit; one more low phase
      // completes that bit cell before the trail.
      SHIFT_LO: if (tick) state_nx = (bits_left == '0) ? TRAIL : SHIFT_HI;
      TRAIL:    if (tick) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    sen   = 2'b11;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ready = 1'b0;
    case (state)
      LEAD, SHIFT_LO, TRAIL: begin
        sen  = sen_sel(dev_lat);
        mosi = data_lat[bit_idx];
      end
      SHIFT_HI: begin
        sen  = sen_sel(dev_lat);
        sclk = 1'b1;
        mosi = data_lat[bit_idx];
      end
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

  // Request latch and bit bookkeeping. The index only moves while more bits
  // remain, so it stops at MAX_BITS-N and holds the last bit through the
  // closing low phase and trail.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dev_lat   <= 1'b0;
      data_lat  <= '0;
      h_lat     <= '0;
      bits_left <= '0;
      bit_idx   <= '0;
    end else if (state == IDLE) begin
      if (start_tr) begin
        dev_lat   <= device;
        data_lat  <= set_data;
        h_lat     <= h_in;
        bits_left <= n_in;
        bit_idx   <= TOP_IDX;
      end
    end else if ((state == SHIFT_HI) && tick) begin
      bits_left <= bits_left - 7'd1;
      if (bits_left > 7'd1) begin
        bit_idx <= bit_idx - IW'(1);
      end
    end
  end

`ifdef CHIRP_SPI_MISO_CAPTURE_EN
  logic [MAX_BITS-1:0] rx_shift;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_shift <= '0;
      readback <= '0;
    end else begin
      if ((state == IDLE) && start_tr) begin
        rx_shift <= '0;
      end else if (tick && (state_nx == SHIFT_HI)) begin
        rx_shift <= {rx_shift[MAX_BITS-2:0], miso};
      end
      if (state == DONE) begin
        readback <= rx_shift;
      end
    end
  end
`endif

endmodule
